// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester arbiter in front of a single memory port. Requester 0 is
//   the fetch side and requester 1 is the data side. At most one transaction
//   is in flight. Ties are broken round-robin using a last-grant register.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   rX_valid/ready         request handshake (X = 0 fetch, 1 data); ready only in IDLE
//   rX_addr/we/wdata       request fields, latched on the accept edge
//   rX_rsp                 one-cycle completion pulse to the owner
//   rsp_rdata              registered read data shared by both requesters
//   mem_req/ready          memory request handshake (req high only in ISSUE)
//   mem_addr/we/wdata      latched request fields presented to memory
//   mem_rvalid/rdata       read return, honoured only in WAIT
//   sel                    current owner; drives downstream 2:1 muxes
module mem_port_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  input  logic              r1_valid,
  output logic              r0_ready,
  output logic              r1_ready,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic              r0_we,
  input  logic              r1_we,
  input  logic [WIDTH-1:0]  r0_wdata,
  input  logic [WIDTH-1:0]  r1_wdata,
  output logic              r0_rsp,
  output logic              r1_rsp,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic              mem_rvalid,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              sel
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e              state_q;
  logic                sel_q;
  logic                last_q;   // requester granted most recently
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [WIDTH-1:0]    wdata_q;
  logic [WIDTH-1:0]    rdata_q;
  logic                r0_rsp_q;
  logic                r1_rsp_q;

  logic idle;
  logic gnt1;
  logic accept;

  // Ready is suppressed while rst is high so nothing is accepted on a reset edge.
  assign idle   = (state_q == S_IDLE) && !rst;
  // Requester 1 wins when alone, or on a tie when requester 0 went last.
  assign gnt1   = r1_valid && (!r0_valid || !last_q);
  assign r1_ready = idle && gnt1;
  assign r0_ready = idle && r0_valid && !gnt1;
  assign accept = r0_ready || r1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      r0_rsp_q <= 1'b0;
      r1_rsp_q <= 1'b0;
    end else begin
      r0_rsp_q <= 1'b0;
      r1_rsp_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            sel_q   <= gnt1;
            last_q  <= gnt1;
            addr_q  <= gnt1 ? r1_addr  : r0_addr;
            we_q    <= gnt1 ? r1_we    : r0_we;
            wdata_q <= gnt1 ? r1_wdata : r0_wdata;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            if (we_q) begin
              // Write is done once memory takes it; acknowledge next cycle.
              r0_rsp_q <= !sel_q;
              r1_rsp_q <= sel_q;
              state_q  <= S_IDLE;
            end else begin
              state_q  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            rdata_q  <= mem_rdata;
            r0_rsp_q <= !sel_q;
            r1_rsp_q <= sel_q;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = (state_q == S_ISSUE);
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign rsp_rdata = rdata_q;
  assign r0_rsp    = r0_rsp_q;
  assign r1_rsp    = r1_rsp_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r1_valid, r0_ready, r1_ready;
  logic [31:0] r0_addr, r1_addr;
  logic        r0_we, r1_we;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_rsp, r1_rsp;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_ready, mem_we, mem_rvalid, sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r1_valid(r1_valid),
    .r0_ready(r0_ready), .r1_ready(r1_ready),
    .r0_addr(r0_addr), .r1_addr(r1_addr),
    .r0_we(r0_we), .r1_we(r1_we),
    .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_rsp(r0_rsp), .r1_rsp(r1_rsp),
    .rsp_rdata(rsp_rdata),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .sel(sel)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change right after a negedge; outputs are checked 1ns later,
  // well away from the rising edge.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_addr = 32'h10; r1_addr = 32'h20;
    r0_we = 1'b0; r1_we = 1'b0;
    r0_wdata = '0; r1_wdata = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0001;

    // ---- reset state ----
    nxt(); nxt();
    #1;
    chk("rst_r0_ready", r0_ready, 0);
    chk("rst_r1_ready", r1_ready, 0);
    chk("rst_sel", sel, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp", {r0_rsp, r1_rsp}, 0);
    rst = 1'b0;

    // ---- both valid, zero-wait reads: 0,1,0,1,0,1 every 3 cycles ----
    for (int c = 0; c < 18; c++) begin
      int g, ph, pg;
      g  = (c / 3) % 2;
      ph = c % 3;
      pg = ((c / 3) + 1) % 2;
      #1;
      if (ph == 0) begin
        chk("rr_r0_ready", r0_ready, g == 0);
        chk("rr_r1_ready", r1_ready, g == 1);
        chk("rr_mem_req_idle", mem_req, 0);
        chk("rr_r0_rsp", r0_rsp, (c > 0) && (pg == 0));
        chk("rr_r1_rsp", r1_rsp, (c > 0) && (pg == 1));
        if (c > 0) chk("rr_rdata", rsp_rdata, 32'hA5A5_0001);
      end else if (ph == 1) begin
        chk("rr_ready_issue", {r0_ready, r1_ready}, 0);
        chk("rr_mem_req", mem_req, 1);
        chk("rr_sel", sel, g);
        chk("rr_mem_addr", mem_addr, (g == 1) ? 32'h20 : 32'h10);
      end else begin
        chk("rr_mem_req_wait", mem_req, 0);
        chk("rr_ready_wait", {r0_ready, r1_ready}, 0);
        chk("rr_rsp_wait", {r0_rsp, r1_rsp}, 0);
      end
      nxt();
    end
    r0_valid = 1'b0; r1_valid = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk("rr_last_r1_rsp", r1_rsp, 1);
    chk("rr_last_r0_rsp", r0_rsp, 0);
    chk("rr_ready_none", {r0_ready, r1_ready}, 0);

    // ---- r1 read 0x100, rdata two cycles after memory accepts ----
    r1_valid = 1'b1; r1_addr = 32'h100; r1_we = 1'b0; mem_ready = 1'b1;
    #1; chk("rd_r1_ready", r1_ready, 1);
    nxt(); r1_valid = 1'b0;
    #1; chk("rd_mem_req", mem_req, 1); chk("rd_mem_addr", mem_addr, 32'h100);
    chk("rd_mem_we", mem_we, 0); chk("rd_sel", sel, 1);
    nxt();
    #1; chk("rd_wait_req", mem_req, 0);
    nxt(); mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1; chk("rd_rsp_early", {r0_rsp, r1_rsp}, 0);
    nxt(); mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1; chk("rd_r1_rsp", r1_rsp, 1); chk("rd_r0_rsp", r0_rsp, 0);
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    nxt();
    #1; chk("rd_r1_rsp_drop", r1_rsp, 0);

    // ---- r0 write 0x40, memory stalls 3 cycles ----
    r0_valid = 1'b1; r0_addr = 32'h40; r0_we = 1'b1; r0_wdata = 32'h12345678;
    mem_ready = 1'b0;
    #1; chk("wr_r0_ready", r0_ready, 1);
    nxt(); r0_valid = 1'b0; r0_addr = 32'h0; r0_wdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_ready = 1'b1;
      #1;
      chk("wr_mem_req", mem_req, 1);
      chk("wr_mem_addr", mem_addr, 32'h40);
      chk("wr_mem_wdata", mem_wdata, 32'h12345678);
      chk("wr_mem_we", mem_we, 1);
      chk("wr_sel", sel, 0);
      chk("wr_rsp_none", {r0_rsp, r1_rsp}, 0);
      nxt();
    end
    mem_ready = 1'b0;
    #1; chk("wr_r0_rsp", r0_rsp, 1); chk("wr_r1_rsp", r1_rsp, 0);
    chk("wr_rdata_kept", rsp_rdata, 32'hDEADBEEF); chk("wr_idle_req", mem_req, 0);
    nxt();
    #1; chk("wr_r0_rsp_drop", r0_rsp, 0);

    // ---- spurious mem_rvalid in IDLE and ISSUE ----
    mem_rvalid = 1'b1; mem_rdata = 32'h0000BAD0;
    nxt();
    #1; chk("sp_idle_rsp", {r0_rsp, r1_rsp}, 0); chk("sp_idle_rdata", rsp_rdata, 32'hDEADBEEF);
    r1_valid = 1'b1; r1_addr = 32'h200; r1_we = 1'b0;
    #1; chk("sp_r1_ready", r1_ready, 1);
    nxt(); r1_valid = 1'b0;
    #1; chk("sp_issue_req", mem_req, 1);
    nxt();
    #1; chk("sp_issue_rsp", {r0_rsp, r1_rsp}, 0); chk("sp_issue_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("sp_issue_hold", mem_req, 1);
    mem_ready = 1'b1; mem_rvalid = 1'b0;
    nxt(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1; chk("sp_wait_req", mem_req, 0); chk("sp_wait_rdata", rsp_rdata, 32'hDEADBEEF);
    nxt(); mem_rvalid = 1'b0;
    #1; chk("sp_done_rsp", r1_rsp, 1); chk("sp_done_rdata", rsp_rdata, 32'hCAFEF00D);

    // ---- reset during WAIT ----
    nxt();
    r1_valid = 1'b1; r1_addr = 32'h300; mem_ready = 1'b1;
    #1; chk("rw_r1_ready", r1_ready, 1);
    nxt(); r1_valid = 1'b0;
    #1; chk("rw_sel1", sel, 1);
    nxt(); rst = 1'b1; r0_valid = 1'b1;
    #1; chk("rw_ready_in_rst", r0_ready, 0);
    nxt(); rst = 1'b0; r0_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    #1; chk("rw_sel0", sel, 0); chk("rw_rsp", {r0_rsp, r1_rsp}, 0);
    chk("rw_mem_req", mem_req, 0); chk("rw_rdata", rsp_rdata, 0);
    nxt(); mem_rvalid = 1'b0; r0_valid = 1'b1; r1_valid = 1'b1;
    #1; chk("rw_late_rsp", {r0_rsp, r1_rsp}, 0); chk("rw_late_rdata", rsp_rdata, 0);
    chk("rw_tie_r0", {r0_ready, r1_ready}, 2'b10);
    nxt(); r0_valid = 1'b0; r1_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of write/read data.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports r0_valid / r1_valid, input, 1 each, requester 0 (fetch) / 1 (data) has a request pending.
REQ-006 SHALL have ports r0_ready / r1_ready, output, 1 each, request accepted this cycle.
REQ-007 SHALL have ports r0_addr / r1_addr, input, ADDR_W each, request address.
REQ-008 SHALL have ports r0_we / r1_we, input, 1 each, 1 = write, 0 = read.
REQ-009 SHALL have ports r0_wdata / r1_wdata, input, WIDTH each, write data.
REQ-010 SHALL have ports r0_rsp / r1_rsp, output, 1 each, one-cycle completion pulse (read data valid or write acknowledged).
REQ-011 SHALL have port rsp_rdata, output, WIDTH, registered read data shared by both requesters.
REQ-012 SHALL have port mem_req, output, 1, memory request.
REQ-013 SHALL have port mem_ready, input, 1, memory accepts mem_req this cycle.
REQ-014 SHALL have ports mem_addr (ADDR_W), mem_we (1), mem_wdata (WIDTH), all outputs, latched request fields.
REQ-015 SHALL have ports mem_rvalid (1) and mem_rdata (WIDTH), inputs, read return.
REQ-016 SHALL have port sel, output, 1, owner of the port; drives the select of the downstream 2:1 muxes (0 = requester 0).

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT; one transaction outstanding at most.
REQ-018 SHALL in IDLE grant a single requester: only one valid -> that one; both valid -> the one not granted last (round-robin via a last-grant register).
REQ-019 SHALL assert rX_ready combinationally in IDLE for the winner only, never both, never outside IDLE.
REQ-020 SHALL on the accept edge latch winner's addr/we/wdata, set sel to winner, update last-grant, go to ISSUE.
REQ-021 SHALL in ISSUE drive mem_req=1 with latched fields, holding them stable until mem_ready=1 at a rising edge.
REQ-022 SHALL on ISSUE with mem_ready=1 and mem_we=1 go to IDLE and pulse owner's rX_rsp in the next cycle.
REQ-023 SHALL on ISSUE with mem_ready=1 and mem_we=0 go to WAIT.
REQ-024 SHALL in WAIT, on mem_rvalid=1, register mem_rdata into rsp_rdata, go to IDLE and pulse owner's rX_rsp in the next cycle.
REQ-025 SHALL hold rsp_rdata until the next read completion; writes do not alter it.
REQ-026 SHALL ignore mem_rvalid outside WAIT.
REQ-027 SHALL allow a new accept in the same cycle as an rX_rsp pulse (IDLE cycle).
REQ-028 SHALL keep sel unchanged in IDLE until the next grant.
REQ-029 SHALL give minimum throughput: zero-wait memory read = 3 cycles accept-to-accept; write = 2.
REQ-030 SHALL keep mem_req=0 in IDLE and WAIT.

Reset
REQ-031 SHALL on rst=1 at a rising edge force state IDLE, sel=0, last-grant=1 (requester 0 wins first tie), r0_rsp=r1_rsp=0, rsp_rdata=0, latched fields 0.
REQ-032 SHALL on reset mid-transaction abandon it with no rsp pulse; ready outputs 0 while rst=1.

Verification
REQ-033 SHALL cover: reset then r0_valid=r1_valid=1, reads -> r0 granted first, then r1; sel 0 then 1.
REQ-034 SHALL cover: r1 read addr 0x100, mem_ready=1 immediately, mem_rvalid with rdata 0xDEADBEEF two cycles later -> r1_rsp one cycle, rsp_rdata=0xDEADBEEF, r0_rsp stays 0.
REQ-035 SHALL cover: r0 write addr 0x40 wdata 0x12345678, mem_ready delayed 3 cycles -> mem_req/mem_addr/mem_wdata stable 4 cycles, r0_rsp one cycle after acceptance, rsp_rdata unchanged.
REQ-036 SHALL cover: spurious mem_rvalid in IDLE and ISSUE -> no rsp pulse, rsp_rdata unchanged.
REQ-037 SHALL cover: rst asserted during WAIT -> next cycle IDLE, sel=0, no rsp; late mem_rvalid ignored.
REQ-038 SHALL cover: both valid continuously, 6 reads with zero-wait memory -> grants alternate 0,1,0,1,0,1, one accept every 3 cycles.
